// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 transmit (pop_to_rs232) and receive (rs232_to_push) paths.
package rs232_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} rs232_state_e;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   // Round-to-nearest clock cycles per bit.
   function automatic int calc_divisor(input int clock_freq, input int baud_rate);
      return (clock_freq + baud_rate / 2) / baud_rate;
   endfunction

endpackage

// File: rtl/pop_to_rs232_if.sv
// Show-ahead FIFO read port: the consumer pops the head byte with a single-cycle strobe.
interface pop_to_rs232_if;
   logic [7:0] data;
   logic       empty;
   logic       pop;

   modport master (output data, output empty, input pop);
   modport slave  (input data, input empty, output pop);
endinterface

// File: rtl/rs232_baud_gen.sv
// Bit-period counter: o_bit_end pulses on the last cycle of every DIVISOR-cycle bit.
module rs232_baud_gen #(
   parameter int DIVISOR = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic i_clear,
   input  logic i_run,
   output logic o_bit_end
);

   localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;

   logic [CW-1:0] r_cnt;

   assign o_bit_end = i_run && (r_cnt == CW'(DIVISOR - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                      r_cnt <= '0;
      else if (i_clear || o_bit_end)  r_cnt <= '0;
      else if (i_run)                 r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/pop_to_rs232.sv
// Drains a show-ahead FIFO onto an 8N1 serial line, gated by the host's RTS# flow control.
module pop_to_rs232
   import rs232_pkg::*;
#(
   parameter int CLOCK_FREQ = 133000000,
   parameter int BAUD_RATE  = 12000000
) (
   input  logic             clock,
   input  logic             reset,
   pop_to_rs232_if.slave    fifo,
   output logic             rxd_pin,
   input  logic             rtsn_pin,
   output logic             busy
);

   localparam int DIVISOR = calc_divisor(CLOCK_FREQ, BAUD_RATE);

   generate
      if (DIVISOR < 2) begin : g_bad_divisor
         $error("pop_to_rs232: DIVISOR must be at least 2");
      end
   endgenerate

   rs232_state_e r_state, w_state_nxt;
   logic [7:0]   r_shift, w_shift_nxt;
   logic [3:0]   r_idx,   w_idx_nxt;
   logic         r_rxd,   w_rxd_nxt;
   logic         r_busy;
   logic         r_sync1, r_sync2;
   logic         w_ready, w_bit_end, w_pop;

   // Synchronizer resets to "not ready" so nothing leaves before RTS# is seen low.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rtsn_pin;
         r_sync2 <= r_sync1;
      end
   end

   assign w_ready = ~r_sync2;

   rs232_baud_gen #(.DIVISOR(DIVISOR)) u_baud (
      .clock     (clock),
      .reset     (reset),
      .i_clear   (w_pop),
      .i_run     (r_state != ST_IDLE),
      .o_bit_end (w_bit_end)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_idx_nxt   = r_idx;
      w_rxd_nxt   = r_rxd;
      // Popping on the last STOP cycle makes back-to-back frames contiguous.
      w_pop = ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end))
              && !fifo.empty && w_ready;
      case (r_state)
         ST_START: if (w_bit_end) begin
            w_state_nxt = ST_DATA;
            w_rxd_nxt   = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_idx_nxt   = 4'd0;
         end
         ST_DATA: if (w_bit_end) begin
            if (r_idx == 4'(DATA_BITS - 1)) begin
               w_state_nxt = ST_STOP;
               w_rxd_nxt   = 1'b1;
            end else begin
               w_rxd_nxt   = r_shift[0];
               w_shift_nxt = {1'b0, r_shift[7:1]};
               w_idx_nxt   = r_idx + 4'd1;
            end
         end
         ST_STOP: if (w_bit_end) begin
            w_state_nxt = ST_IDLE;
            w_rxd_nxt   = 1'b1;
         end
         default: ;
      endcase
      if (w_pop) begin
         w_state_nxt = ST_START;
         w_shift_nxt = fifo.data;
         w_idx_nxt   = 4'd0;
         w_rxd_nxt   = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_idx   <= '0;
         r_rxd   <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_idx   <= w_idx_nxt;
         r_rxd   <= w_rxd_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
      end
   end

   assign fifo.pop = w_pop;
   assign rxd_pin  = r_rxd;
   assign busy     = r_busy;

endmodule

// File: doc/pop_to_rs232.md
POP_TO_RS232 -- requirements
Module: pop_to_rs232

Interface
REQ-001 Parameter CLOCK_FREQ, default 133000000, clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 12000000, serial bit rate in bit/s.
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 data  input  8  byte at head of upstream show-ahead FIFO; valid whenever empty=0.
REQ-006 empty  input  1  upstream FIFO has no byte.
REQ-007 pop  output  1  one-cycle strobe; consumes data in the same cycle.
REQ-008 rxd_pin  output  1  serial line to host (idle high).
REQ-009 rtsn_pin  input  1  host flow control, active low = host ready to receive; asynchronous.
REQ-010 busy  output  1  high while a frame is on the line.

Function
REQ-011 DIVISOR SHALL be (CLOCK_FREQ + BAUD_RATE/2) / BAUD_RATE, integer; defaults give 11; elaboration SHALL fail if DIVISOR < 2.
REQ-012 rtsn_pin SHALL pass a 2-flop synchronizer; "ready" = synchronized rtsn low.
REQ-013 Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly DIVISOR cycles; frame = 10*DIVISOR cycles.
REQ-014 States IDLE, START, DATA, STOP; 4-bit bit index and ceil(log2(DIVISOR))-bit cycle counter.
REQ-015 pop SHALL be combinational: 1 iff (state=IDLE or last cycle of STOP) and empty=0 and ready=1.
REQ-016 On a pop cycle, data SHALL be latched into the shift register, state -> START, counter cleared; rxd_pin (registered) goes 0 at that same edge.
REQ-017 START -> DATA after DIVISOR cycles; DATA shifts one bit per DIVISOR cycles, -> STOP after bit 7; STOP -> IDLE after DIVISOR cycles unless pop occurs (-> START).
REQ-018 Back-to-back bytes SHALL produce contiguous frames with no idle cycle between stop and next start bit.
REQ-019 ready going 0 mid-frame SHALL NOT abort the frame; it only blocks the next pop.
REQ-020 empty=1 at end of STOP: rxd_pin stays 1, state IDLE, pop=0.
REQ-021 pop SHALL never exceed one assertion per frame; data is never read when empty=1.
REQ-022 busy = (state != IDLE), registered with state.

Reset
REQ-023 While reset=1: rxd_pin=1, busy=0, pop=0, state=IDLE, counters 0, synchronizer flops 1 (not ready).
REQ-024 Reset mid-frame SHALL force rxd_pin=1 immediately (asynchronous); the partial byte is lost, not re-sent.
REQ-025 After reset release, first pop no earlier than the 3rd rising edge (synchronizer fill).

Structure
REQ-026 Shared package rs232_pkg SHALL hold the state enum, DIVISOR computation function and frame constants (data bits 8, stop bits 1), shared with rs232_to_push.
REQ-027 One sub-module rs232_baud_gen: counter producing a one-cycle bit_end strobe every DIVISOR cycles, cleared on frame start.
REQ-028 rxd_pin SHALL be driven directly from a flop (no combinational path to pin).

Verification (CLOCK_FREQ=16, BAUD_RATE=4, DIVISOR=4 unless noted)
REQ-029 Single byte 0xA5, rtsn=0 -> one pop; rxd_pin 0,1,0,1,0,0,1,0,1,1 each 4 cycles (40 cycles), then idle high, busy low.
REQ-030 FIFO holds 0x00,0xFF,0x55 -> 3 pops 40 cycles apart; 120 contiguous line cycles, no gap.
REQ-031 rtsn=1 with empty=0 -> no pop, rxd_pin=1; rtsn->0 -> pop within 3 cycles; rtsn->1 at bit 3 -> frame completes, no further pop.
REQ-032 reset=1 during DATA bit 4 -> rxd_pin=1 same cycle without clock edge; after release next byte frames correctly.
REQ-033 Defaults (133 MHz/12 Mbaud) with 0x3C -> 11 cycles per bit, 110 per frame; decoded by rs232_to_push loopback -> 0x3C.
REQ-034 Random bytes/empty/rtsn for 10^5 cycles -> loopback byte stream equals pop stream; pop never with empty=1.
